aes_stream_decipher_rx: RTL and testbench

//  Receive-side decryptor for the byte-serial AES-inverse-S-box stream cipher link.

---
 rtl/aes_stream_pkg.sv | 28 ++
 rtl/aes_stream_decipher_rx_fifo.sv | 60 ++++++
 rtl/aes_stream_decipher_rx.sv | 91 +++++++++
 tb/tb_aes_stream_decipher_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared keystream table for the AES inverse-S-box stream cipher link.
// Both ends of the link look up the same table through keystream().
package aes_stream_pkg;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] keystream(input logic [7:0] idx);
        return INV_SBOX[idx];
    endfunction

endpackage

// File: rtl/aes_stream_decipher_rx_fifo.sv
// First-word-fall-through synchronous FIFO for plaintext bytes.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_stream_decipher_rx.sv
// Receive-side keystream regeneration, decrypt XOR and plaintext buffering.
// The link has no backpressure, so bytes arriving into a full FIFO are dropped.
module aes_stream_decipher_rx
    import aes_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             new_message,
    input  logic [7:0]       key,
    input  logic [7:0]       data_in,
    input  logic             valid_in,
    output logic [7:0]       data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             overflow,
    output logic [CNT_W-1:0] msg_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               CW      = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    ks_ctr;
    logic [7:0]    plain;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          push;
    logic          drop;

    assign plain     = data_in ^ keystream(ks_ctr);
    assign valid_out = ~fifo_empty;
    assign pop       = valid_out & ready_in;
    assign push      = valid_in & ((fifo_count < CW'(FIFO_DEPTH)) | pop);
    assign drop      = valid_in & fifo_full & ~pop;
    assign data_out  = valid_out ? fifo_dout : 8'h00;

    byte_fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (plain),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Keystream index free-runs every cycle to stay locked to the transmitter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ks_ctr <= 8'h00;
        end else if (new_message) begin
            ks_ctr <= key;
        end else begin
            ks_ctr <= ks_ctr + 8'h01;
        end
    end

    // Sticky drop flag; a new message starts clean, but a drop in that same
    // cycle belongs to the new message and still raises it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (new_message) begin
            overflow <= drop;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Saturating count of bytes accepted since the last message start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_count <= '0;
        end else if (new_message) begin
            msg_count <= push ? CNT_W'(1) : '0;
        end else if (push && msg_count != CNT_MAX) begin
            msg_count <= msg_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_stream_decipher_rx.sv
// Self-checking bench for aes_stream_decipher_rx.
// Keystream table is rebuilt here from GF(2^8) arithmetic.
module tb_aes_stream_decipher_rx;

    logic        clk;
    logic        reset_n;
    logic        new_message;
    logic [7:0]  key;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_in;
    logic        overflow;
    logic [15:0] msg_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] invsb [256];

    logic [7:0]  q [$];
    logic [7:0]  m_ks;
    logic        m_ovf;
    logic [15:0] m_cnt;

    typedef struct {
        logic        nm;
        logic [7:0]  key;
        logic        vin;
        logic [7:0]  din;
        logic        ev;
        logic [7:0]  ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs [$];

    aes_stream_decipher_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .new_message (new_message),
        .key         (key),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .overflow    (overflow),
        .msg_count   (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_table();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
            invsb[s] = 8'(x);
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic nm, input logic [7:0] k,
                         input logic v, input logic [7:0] d);
        new_message = nm;
        key = k;
        valid_in = v;
        data_in = d;
    endtask

    // Scoreboard: compare against the model, then advance it for the next edge.
    always @(negedge clk) begin
        logic pop;
        logic push;
        logic drop;
        if (!reset_n) begin
            q.delete();
            m_ks = 8'h00;
            m_ovf = 1'b0;
            m_cnt = 16'h0;
        end else begin
            check("sb_valid", 16'(valid_out), 16'(q.size() != 0));
            check("sb_data", 16'(data_out), 16'(q.size() != 0 ? q[0] : 8'h00));
            check("sb_ovf", 16'(overflow), 16'(m_ovf));
            check("sb_cnt", msg_count, m_cnt);
            pop = (q.size() != 0) && ready_in;
            push = valid_in && (q.size() < 8 || pop);
            drop = valid_in && !push;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(data_in ^ invsb[m_ks]);
            m_ovf = new_message ? drop : (m_ovf | drop);
            if (new_message) m_cnt = push ? 16'h1 : 16'h0;
            else if (push && m_cnt != 16'hffff) m_cnt = m_cnt + 16'h1;
            m_ks = new_message ? key : m_ks + 8'h01;
        end
    end

    task automatic addv(input logic nm, input logic [7:0] k, input logic v,
                        input logic [7:0] d, input logic ev, input logic [7:0] ed,
                        input logic [15:0] ec);
        vec_t r;
        r.nm = nm; r.key = k; r.vin = v; r.din = d;
        r.ev = ev; r.ed = ed; r.ec = ec;
        vecs.push_back(r);
    endtask

    task automatic drain(input string name, input int exp_n, output logic [7:0] last);
        int n = 0;
        last = 8'h00;
        drive(0, 8'h00, 0, 8'h00);
        ready_in = 1'b1;
        while (valid_out && n < 20) begin
            last = data_out;
            step();
            n++;
        end
        check(name, 16'(n), 16'(exp_n));
    endtask

    initial begin
        logic [7:0] last;
        build_table();
        reset_n = 1'b0;
        ready_in = 1'b0;
        drive(0, 8'h00, 0, 8'h00);

        // basic, keystream wrap, idle gap
        addv(1, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        addv(0, 8'h00, 1, 8'h52, 1, 8'h00, 16'd1);
        addv(0, 8'h00, 1, 8'h48, 1, 8'h41, 16'd2);
        addv(0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd2);
        addv(1, 8'hFF, 0, 8'h00, 0, 8'h00, 16'd0);
        addv(0, 8'h00, 1, 8'h7D, 1, 8'h00, 16'd1);
        addv(0, 8'h00, 1, 8'h52, 1, 8'h00, 16'd2);
        addv(0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd2);
        addv(1, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        addv(0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        addv(0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd0);
        addv(0, 8'h00, 1, 8'h6A, 1, 8'h00, 16'd1);
        addv(0, 8'h00, 0, 8'h00, 0, 8'h00, 16'd1);

        step();
        step();
        check("rst_valid", 16'(valid_out), 16'd0);
        check("rst_data", 16'(data_out), 16'd0);
        check("rst_cnt", msg_count, 16'd0);
        reset_n = 1'b1;
        ready_in = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].nm, vecs[i].key, vecs[i].vin, vecs[i].din);
            step();
            check($sformatf("vec%0d_valid", i), 16'(valid_out), 16'(vecs[i].ev));
            check($sformatf("vec%0d_data", i), 16'(data_out), 16'(vecs[i].ed));
            check($sformatf("vec%0d_cnt", i), msg_count, vecs[i].ec);
        end

        // full FIFO with simultaneous pop and push
        ready_in = 1'b0;
        drive(1, 8'h80, 0, 8'h00);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 8'h00, 1, 8'($urandom_range(0, 255)));
            step();
        end
        check("full_cnt", msg_count, 16'd8);
        check("full_ovf", 16'(overflow), 16'd0);
        drive(0, 8'h00, 1, 8'hEE);
        ready_in = 1'b1;
        step();
        check("fp_ovf", 16'(overflow), 16'd0);
        check("fp_cnt", msg_count, 16'd9);
        check("fp_valid", 16'(valid_out), 16'd1);
        drain("fp_depth", 8, last);
        check("fp_last", 16'(last), 16'(8'hEE ^ invsb[8'h88]));

        // overflow: nine bytes into an eight-entry FIFO
        ready_in = 1'b0;
        drive(1, 8'h3C, 0, 8'h00);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(0, 8'h00, 1, 8'($urandom_range(0, 255)));
            step();
        end
        check("ov_valid", 16'(valid_out), 16'd1);
        check("ov_flag", 16'(overflow), 16'd1);
        check("ov_cnt", msg_count, 16'd8);
        drain("ov_drain", 8, last);
        check("ov_sticky", 16'(overflow), 16'd1);

        // asynchronous reset with bytes in flight
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 8'(8'h10 + i));
            step();
        end
        drive(0, 8'h00, 0, 8'h00);
        check("pre_rst_valid", 16'(valid_out), 16'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 16'(valid_out), 16'd0);
        check("arst_data", 16'(data_out), 16'd0);
        check("arst_ovf", 16'(overflow), 16'd0);
        check("arst_cnt", msg_count, 16'd0);
        step();
        reset_n = 1'b1;
        ready_in = 1'b1;
        drive(0, 8'h00, 1, 8'h52);
        step();
        check("post_rst_data", 16'(data_out), 16'd0);
        drive(0, 8'h00, 0, 8'h00);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
